// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the S-box used by key expansion and sub_bytes.
package aes_pkg;

  localparam int KW   = 128;
  localparam int WORD = 32;

  localparam logic [7:0] AES_RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Inverse as a^254 (zero maps to zero), then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-in / round-key-out handshake bundle for aes_key_expand.
// Read-port signals exist only when AES_KEY_EXPAND_STORE_EN is defined.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic          key_valid;
  logic          key_ready;
  logic [KW-1:0] key_in;
  logic          rk_valid;
  logic          rk_ready;
  logic [KW-1:0] rk_out;
  logic [3:0]    rk_idx;
  logic          busy;
`ifdef AES_KEY_EXPAND_STORE_EN
  logic [3:0]    rd_idx;
  logic [KW-1:0] rd_key;

  modport master (
    output key_valid, key_in, rk_ready, rd_idx,
    input  key_ready, rk_valid, rk_out, rk_idx, busy, rd_key
  );
  modport slave (
    input  key_valid, key_in, rk_ready, rd_idx,
    output key_ready, rk_valid, rk_out, rk_idx, busy, rd_key
  );
`else
  modport master (
    output key_valid, key_in, rk_ready,
    input  key_ready, rk_valid, rk_out, rk_idx, busy
  );
  modport slave (
    input  key_valid, key_in, rk_ready,
    output key_ready, rk_valid, rk_out, rk_idx, busy
  );
`endif

endinterface

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four independent S-box lookups, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD-1:0] word,
  output logic [WORD-1:0] sub
);

  always_comb begin
    sub = '0;
    for (int b = 0; b < 4; b++) begin
      sub[8*b +: 8] = sbox(word[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule streaming round keys 0..10 with valid/ready backpressure.
// Optional round-key store with read port: define AES_KEY_EXPAND_STORE_EN.
//
// state | meaning
// IDLE  | waiting for a cipher key, key_ready high
// EMIT  | presenting rk_out/rk_idx, advancing one round per output handshake
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10,
  parameter int KW         = 128
) (
  input logic             clk,
  input logic             rst,
  aes_key_expand_if.slave bus
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t          state;
  state_t          state_nxt;
  logic            idle_rdy;
  logic            load;
  logic            advance;
  logic            finish;

  logic [KW-1:0]   rk_q;
  logic [KW-1:0]   rk_nxt;
  logic [3:0]      idx_q;
  logic            valid_q;
  logic            busy_q;

  logic [WORD-1:0] w0, w1, w2, w3;
  logic [WORD-1:0] rot;
  logic [WORD-1:0] sub;
  logic [WORD-1:0] t;
  logic [WORD-1:0] n0, n1, n2, n3;
  logic [7:0]      rcon;

  // Next round key is derived straight from the output register.
  assign {w0, w1, w2, w3} = rk_q;
  assign rot = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word (rot),
    .sub  (sub)
  );

  assign rcon   = (idx_q < LAST_IDX) ? AES_RCON[idx_q] : 8'h00;
  assign t      = sub ^ {rcon, 24'h000000};
  assign n0     = w0 ^ t;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign rk_nxt = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idle_rdy  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        idle_rdy = 1'b1;
        if (bus.key_valid) begin
          load      = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (valid_q && bus.rk_ready) begin
          if (idx_q == LAST_IDX) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (load) begin
      rk_q    <= bus.key_in;
      idx_q   <= '0;
      valid_q <= 1'b1;
      busy_q  <= 1'b1;
    end else if (advance) begin
      rk_q  <= rk_nxt;
      idx_q <= idx_q + 4'd1;
    end else if (finish) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end
  end

  assign bus.key_ready = idle_rdy;
  assign bus.rk_valid  = valid_q;
  assign bus.rk_out    = rk_q;
  assign bus.rk_idx    = idx_q;
  assign bus.busy      = busy_q;

`ifdef AES_KEY_EXPAND_STORE_EN
  logic [KW-1:0] key_store [0:NUM_ROUNDS];

  // Captured on the output handshake, so only keys actually delivered are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) key_store[i] <= '0;
    end else if (valid_q && bus.rk_ready) begin
      key_store[idx_q] <= rk_q;
    end
  end

  assign bus.rd_key = (bus.rd_idx <= LAST_IDX) ? key_store[bus.rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a FIPS-197 word-schedule model.
module tb_aes_key_expand;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy_mode = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  aes_key_expand_if bus ();

  aes_key_expand #(.NUM_ROUNDS(10), .KW(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3.
  logic [7:0] sbox [0:255];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Protocol model: what the stream must look like, tracked per clock edge.
  logic         m_emit = 1'b0;
  int           m_idx = 0;
  logic [127:0] m_keys  [0:10];
  logic [127:0] m_store [0:10];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_emit <= 1'b0;
      m_idx  <= 0;
      for (int i = 0; i <= 10; i++) m_store[i] <= '0;
    end else if (!m_emit) begin
      if (bus.key_valid === 1'b1) begin
        for (int r = 0; r <= 10; r++) m_keys[r] <= round_key(bus.key_in, r);
        m_emit <= 1'b1;
        m_idx  <= 0;
      end
    end else if (bus.rk_ready === 1'b1) begin
      m_store[m_idx] <= m_keys[m_idx];
      if (m_idx == 10) m_emit <= 1'b0;
      else             m_idx  <= m_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_key_ready", 128'(bus.key_ready), 128'd1);
      check("rst_rk_valid",  128'(bus.rk_valid),  128'd0);
      check("rst_rk_idx",    128'(bus.rk_idx),    128'd0);
      check("rst_busy",      128'(bus.busy),      128'd0);
      check("rst_rk_out",    bus.rk_out,          128'd0);
    end else begin
      check("key_ready", 128'(bus.key_ready), 128'(!m_emit));
      check("rk_valid",  128'(bus.rk_valid),  128'(m_emit));
      check("busy",      128'(bus.busy),      128'(m_emit));
      if (m_emit) begin
        check("rk_idx", 128'(bus.rk_idx), 128'(m_idx));
        check("rk_out", bus.rk_out, m_keys[m_idx]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.rk_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic start_key(input logic [127:0] k);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.key_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_key: key_ready never seen for key %h", k);
    end
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.key_ready) break;
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: key_ready still %b after 200 cycles, required 1", name, bus.key_ready);
    end
  endtask

`ifdef AES_KEY_EXPAND_STORE_EN
  task automatic sweep_store(input string name, input bit expect_zero);
    logic [127:0] exp;
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      exp = '0;
      if (!expect_zero && i <= 10) exp = m_store[i];
      check(name, bus.rd_key, exp);
    end
  endtask
`endif

  initial begin
    int cnt;
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
`ifdef AES_KEY_EXPAND_STORE_EN
    bus.rd_idx    = '0;
`endif
    build_sbox();
    check("pin_sbox_00", 128'(sbox[8'h00]), 128'h63);
    check("pin_sbox_01", 128'(sbox[8'h01]), 128'h7c);
    check("pin_sbox_53", 128'(sbox[8'h53]), 128'hed);
    check("pin_model_fips0",  round_key(FIPS_KEY, 0), FIPS_KEY);
    check("pin_model_fips1",  round_key(FIPS_KEY, 1), FIPS_RK1);
    check("pin_model_fips10", round_key(FIPS_KEY, 10), FIPS_RK10);
    check("pin_model_zero10", round_key(128'd0, 10), ZERO_RK10);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // FIPS key, consumer always ready
    start_key(FIPS_KEY);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.key_ready) break;
      if (bus.rk_valid) begin
        cnt++;
        if (bus.rk_idx == 4'd0)  check("fips_idx0",  bus.rk_out, FIPS_KEY);
        if (bus.rk_idx == 4'd1)  check("fips_idx1",  bus.rk_out, FIPS_RK1);
        if (bus.rk_idx == 4'd10) check("fips_idx10", bus.rk_out, FIPS_RK10);
      end
    end
    check("fips_valid_cycles", 128'(cnt), 128'd11);
    check("fips_busy_after",   128'(bus.busy), 128'd0);
`ifdef AES_KEY_EXPAND_STORE_EN
    bus.rd_idx = 4'd1;
    #1 check("rd_idx1", bus.rd_key, FIPS_RK1);
    bus.rd_idx = 4'd12;
    #1 check("rd_idx12", bus.rd_key, 128'd0);
    sweep_store("rd_after_fips", 1'b0);
`endif

    // same key under random backpressure
    rdy_mode = 1'b1;
    start_key(FIPS_KEY);
    wait_idle("stall_run");

    // new key offered while busy must be ignored
    start_key(FIPS_KEY);
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.key_in    = '0;
      bus.key_valid = 1'b1;
      check("ignore_key_ready", 128'(bus.key_ready), 128'd0);
    end
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
    wait_idle("ignore_run");

    // asynchronous reset at round 5
    rdy_mode = 1'b0;
    start_key({$urandom, $urandom, $urandom, $urandom});
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_idx == 4'd5) begin
        cnt = 1;
        break;
      end
    end
    check("reach_idx5", 128'(cnt), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rk_valid",  128'(bus.rk_valid),  128'd0);
    check("async_rk_idx",    128'(bus.rk_idx),    128'd0);
    check("async_key_ready", 128'(bus.key_ready), 128'd1);
    check("async_busy",      128'(bus.busy),      128'd0);
`ifdef AES_KEY_EXPAND_STORE_EN
    sweep_store("rd_after_rst", 1'b1);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_mode = 1'b1;
    start_key(FIPS_KEY);
    wait_idle("post_rst_run");

    // back-to-back: zero key then FIPS key held on key_in
    rdy_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.key_in    = '0;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1 bus.key_in = FIPS_KEY;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.key_ready) begin
        cnt = 1;
        break;
      end
      if (bus.rk_valid && bus.rk_idx == 4'd10) check("zero_idx10", bus.rk_out, ZERO_RK10);
    end
    check("b2b_idle_seen", 128'(cnt), 128'd1);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    check("b2b_rk_valid", 128'(bus.rk_valid), 128'd1);
    check("b2b_rk_idx",   128'(bus.rk_idx),   128'd0);
    check("b2b_rk_out",   bus.rk_out,         FIPS_KEY);
    wait_idle("b2b_run");

    // random keys, random backpressure and gaps
    for (int n = 0; n < 6; n++) begin
      rdy_mode = 1'($urandom_range(0, 1));
      start_key({$urandom, $urandom, $urandom, $urandom});
      wait_idle("random_run");
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
`ifdef AES_KEY_EXPAND_STORE_EN
    @(negedge clk);
    sweep_store("rd_final", 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule; accepts one 128-bit cipher key and streams the 11 round keys (round 0..10) in order.
- Sits directly upstream of the add-round-key stage and drives its roundkey_in input, one round key per handshake.
- Computes one round key per cycle with valid/ready backpressure on the output, so a stalled datapath never loses a key.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; fixed at 10 for AES-128, other values unsupported.
- KW, 128, key and round-key width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  block is idle and can accept a key.
- key_in  in  128  cipher key, FIPS-197 byte order (MSB = byte 0).
- rk_valid  out  1  rk_out/rk_idx hold a valid round key.
- rk_ready  in  1  consumer accepts the round key this cycle.
- rk_out  out  128  current round key, same byte order as key_in.
- rk_idx  out  4  round index of rk_out, 0..10.
- busy  out  1  high from key acceptance until the round-10 handshake completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE, key_ready=1, rk_valid=0, rk_out=0, rk_idx=0, busy=0, internal rcon index=0.
- Handshakes:
  - Input handshake = key_valid & key_ready.
  - Output handshake = rk_valid & rk_ready.
  - Both handshakes take effect on the clock edge.
- FSM states: IDLE, EMIT.
- IDLE:
  - key_ready=1.
  - On input handshake: rk_out<=key_in, rk_idx<=0, rk_valid<=1, busy<=1, go to EMIT.
  - Latency is 1 cycle from key acceptance to round-0 valid.
- EMIT:
  - key_ready=0; key_valid is ignored and no key is captured.
  - rk_out, rk_idx and rk_valid are held stable while rk_ready=0.
  - Output handshake with rk_idx<10: rk_out<=expand(rk_out, rcon[rk_idx]) and rk_idx<=rk_idx+1; rk_valid stays 1.
  - With rk_ready held high, throughput is 1 round key per cycle; all 11 keys take 11 consecutive cycles.
  - Output handshake with rk_idx==10: rk_valid<=0, busy<=0, go to IDLE. key_ready is high the following cycle, with no bubble beyond that one cycle.
- expand(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}
  - w0' = w0 ^ t
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - Purely combinational from the rk_out register; rk_out is the only key storage.
- rcon sequence for rk_idx 0..9: 01,02,04,08,10,20,40,80,1b,36.
- rk_idx never exceeds 10 and never wraps.
- Reset mid-stream: the key in flight is discarded; outputs return to reset values immediately, without waiting for a clock edge.
- key_valid and rk_ready asserted in the same cycle while in IDLE: only the input handshake is meaningful, because rk_valid=0 in IDLE.

Optional Feature:
- Macro: AES_KEY_EXPAND_STORE_EN.
- When defined:
  - Adds a register file of 11x128 bits, written with each round key as it is emitted.
  - Adds ports rd_idx (in, 4) and rd_key (out, 128).
  - rd_key = stored key[rd_idx], combinational read; rd_key=0 for rd_idx>10.
  - Contents survive the return to IDLE and are cleared to 0 by rst.
  - Lets decryption re-read keys without re-expanding.
- When undefined: no storage and no rd_* ports; behaviour is otherwise identical.

Decomposition:
- Package aes_pkg holds:
  - AES_RCON[0:9] constant.
  - Width constants KW=128 and WORD=32.
  - FSM state typedef {IDLE, EMIT}.
  - The S-box function/table, shared with the sub_bytes stage.
- One sub-module, aes_sub_word: 32-bit SubWord built from 4 S-box lookups, purely combinational, instantiated once.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> rk_out sequence:
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - 11 consecutive valid cycles, then busy=0 and key_ready=1.
- Same key with rk_ready toggled randomly -> identical 11-key sequence; rk_out/rk_idx unchanged during every stall cycle.
- key_valid pulsed with key 000...0 while busy -> ignored; the original sequence completes unaltered, key_ready=0 throughout.
- rst asserted asynchronously while rk_idx=5 -> rk_valid=0, rk_idx=0, key_ready=1 before the next edge; a fresh key then expands correctly from idx0.
- Back-to-back keys: all-zero key, then FIPS key -> all-zero idx10 = b4ef5bcb3e92e21123e951cf6f8f188e; FIPS sequence follows after the 1-cycle IDLE.
- With AES_KEY_EXPAND_STORE_EN: after the FIPS run, rd_idx=1 -> a0fafe1788542cb123a339392a6c7605; rd_idx=12 -> 0; after rst, every rd_idx -> 0.
